// File: rtl/exe_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, shifter and forwarding
// select codes, and the NZCV status word.
package exe_pkg;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;

  localparam logic [1:0] SHIFT_LSL = 2'b00;
  localparam logic [1:0] SHIFT_LSR = 2'b01;
  localparam logic [1:0] SHIFT_ASR = 2'b10;
  localparam logic [1:0] SHIFT_ROR = 2'b11;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } status_t;

endpackage

// File: rtl/exe_if.sv
// ID/EXE inputs and EXE/MEM outputs of the execute stage; the ID side is the
// master, the execute stage is the slave.
interface exe_if import exe_pkg::*; #(parameter int WIDTH = 32);
  logic             freeze;
  logic [3:0]       EXE_CMD;
  logic             MEM_R_EN_IN;
  logic             MEM_W_EN_IN;
  logic             WB_EN_IN;
  logic             S;
  logic             B;
  logic             imm;
  logic [WIDTH-1:0] PC;
  logic [WIDTH-1:0] Val_Rn;
  logic [WIDTH-1:0] Val_Rm;
  logic [11:0]      shift_operand;
  logic [23:0]      signed_imm_24;
  logic [3:0]       DestIn;
  logic [1:0]       sel_src1;
  logic [1:0]       sel_src2;
  logic [WIDTH-1:0] MEM_ALUResult;
  logic [WIDTH-1:0] WB_Value;

  logic [WIDTH-1:0] ALUResult;
  logic [WIDTH-1:0] storeValue;
  logic [3:0]       WBDest;
  logic             MEM_R_EN;
  logic             MEM_W_EN;
  logic             WB_EN;
  status_t          SR;
  logic             Branch_taken;
  logic [WIDTH-1:0] Branch_address;
  logic [3:0]       EXE_WBDest;
  logic             EXE_WB_EN;
  logic             EXE_MEM_R_EN;

  modport master (
    output freeze, EXE_CMD, MEM_R_EN_IN, MEM_W_EN_IN, WB_EN_IN, S, B, imm, PC,
           Val_Rn, Val_Rm, shift_operand, signed_imm_24, DestIn, sel_src1,
           sel_src2, MEM_ALUResult, WB_Value,
    input  ALUResult, storeValue, WBDest, MEM_R_EN, MEM_W_EN, WB_EN, SR,
           Branch_taken, Branch_address, EXE_WBDest, EXE_WB_EN, EXE_MEM_R_EN
  );

  modport slave (
    input  freeze, EXE_CMD, MEM_R_EN_IN, MEM_W_EN_IN, WB_EN_IN, S, B, imm, PC,
           Val_Rn, Val_Rm, shift_operand, signed_imm_24, DestIn, sel_src1,
           sel_src2, MEM_ALUResult, WB_Value,
    output ALUResult, storeValue, WBDest, MEM_R_EN, MEM_W_EN, WB_EN, SR,
           Branch_taken, Branch_address, EXE_WBDest, EXE_WB_EN, EXE_MEM_R_EN
  );
endinterface

// File: rtl/exe_alu.sv
// Combinational ALU: result plus next NZCV. Subtraction runs through the adder
// as A + ~B + cin so carry means "no borrow".
module exe_alu import exe_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] val2,
  input  logic [3:0]       cmd,
  input  status_t          srIn,
  output logic [WIDTH-1:0] result,
  output status_t          flags
);

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] opB;
  logic             cin;
  logic             arith;
  logic             known;

  always_comb begin
    opB   = val2;
    cin   = 1'b0;
    arith = 1'b0;
    case (cmd)
      CMD_ADD: arith = 1'b1;
      CMD_ADC: begin arith = 1'b1; cin = srIn.c; end
      CMD_SUB: begin arith = 1'b1; opB = ~val2; cin = 1'b1; end
      CMD_SBC: begin arith = 1'b1; opB = ~val2; cin = srIn.c; end
      default: ;
    endcase
    sum = {1'b0, a} + {1'b0, opB} + {{WIDTH{1'b0}}, cin};

    result = '0;
    known  = 1'b1;
    case (cmd)
      CMD_MOV:                            result = val2;
      CMD_MVN:                            result = ~val2;
      CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: result = sum[WIDTH-1:0];
      CMD_AND:                            result = a & val2;
      CMD_ORR:                            result = a | val2;
      CMD_EOR:                            result = a ^ val2;
      default:                            known  = 1'b0;
    endcase

    // Unknown opcodes leave every flag untouched; logic ops only refresh N/Z.
    flags = srIn;
    if (known) begin
      flags.n = result[WIDTH-1];
      flags.z = (result == '0);
    end
    if (arith) begin
      flags.c = sum[WIDTH];
      flags.v = (a[WIDTH-1] == opB[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
    end
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: operand forwarding, Val2 shifter, ALU, NZCV register, branch
// target and the EXE/MEM pipeline register.
module exe_stage import exe_pkg::*; #(
  parameter int WIDTH = 32
) (
  input logic  clk,
  input logic  rst,
  exe_if.slave bus
);

  function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] x,
                                            input logic [4:0]       amt);
    logic [2*WIDTH-1:0] t;
    t = {x, x} >> amt;
    return t[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] shiftVal(input logic [WIDTH-1:0] x,
                                                input logic [1:0]       kind,
                                                input logic [4:0]       amt);
    logic signed [WIDTH-1:0] xs;
    xs = x;
    case (kind)
      SHIFT_LSL: return x << amt;
      SHIFT_LSR: return x >> amt;
      SHIFT_ASR: return xs >>> amt;
      default:   return rotr(x, amt);
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] fwdSel(input logic [1:0]       sel,
                                              input logic [WIDTH-1:0] regVal,
                                              input logic [WIDTH-1:0] memVal,
                                              input logic [WIDTH-1:0] wbVal);
    case (sel)
      FWD_MEM: return memVal;
      FWD_WB:  return wbVal;
      default: return regVal;
    endcase
  endfunction

  logic [WIDTH-1:0] src1_p0, src2_p0, val2_p0, aluResult_p0;
  status_t          flags_p0;

  logic [WIDTH-1:0] aluResult_p1, storeValue_p1;
  logic [3:0]       wbDest_p1;
  logic             memREn_p1, memWEn_p1, wbEn_p1;
  status_t          sr_p1;

  assign src1_p0 = fwdSel(bus.sel_src1, bus.Val_Rn, bus.MEM_ALUResult, bus.WB_Value);
  assign src2_p0 = fwdSel(bus.sel_src2, bus.Val_Rm, bus.MEM_ALUResult, bus.WB_Value);

  // Memory accesses take the raw 12-bit offset; otherwise immediate or shifted register.
  always_comb begin
    if (bus.MEM_R_EN_IN || bus.MEM_W_EN_IN)
      val2_p0 = {{(WIDTH-12){1'b0}}, bus.shift_operand};
    else if (bus.imm)
      val2_p0 = rotr({{(WIDTH-8){1'b0}}, bus.shift_operand[7:0]},
                     {bus.shift_operand[11:8], 1'b0});
    else
      val2_p0 = shiftVal(src2_p0, bus.shift_operand[6:5], bus.shift_operand[11:7]);
  end

  exe_alu #(.WIDTH(WIDTH)) uAlu (
    .a      (src1_p0),
    .val2   (val2_p0),
    .cmd    (bus.EXE_CMD),
    .srIn   (sr_p1),
    .result (aluResult_p0),
    .flags  (flags_p0)
  );

  // ---- EXE/MEM boundary ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aluResult_p1  <= '0;
      storeValue_p1 <= '0;
      wbDest_p1     <= '0;
      memREn_p1     <= 1'b0;
      memWEn_p1     <= 1'b0;
      wbEn_p1       <= 1'b0;
      sr_p1         <= '0;
    end else if (!bus.freeze) begin
      aluResult_p1  <= aluResult_p0;
      storeValue_p1 <= src2_p0;
      wbDest_p1     <= bus.DestIn;
      memREn_p1     <= bus.MEM_R_EN_IN;
      memWEn_p1     <= bus.MEM_W_EN_IN;
      wbEn_p1       <= bus.WB_EN_IN;
      if (bus.S) sr_p1 <= flags_p0;
    end
  end

  assign bus.ALUResult  = aluResult_p1;
  assign bus.storeValue = storeValue_p1;
  assign bus.WBDest     = wbDest_p1;
  assign bus.MEM_R_EN   = memREn_p1;
  assign bus.MEM_W_EN   = memWEn_p1;
  assign bus.WB_EN      = wbEn_p1;
  assign bus.SR         = sr_p1;

  assign bus.Branch_taken   = bus.B;
  assign bus.Branch_address = bus.PC + {{(WIDTH-26){bus.signed_imm_24[23]}},
                                        bus.signed_imm_24, 2'b00};
  assign bus.EXE_WBDest     = bus.DestIn;
  assign bus.EXE_WB_EN      = bus.WB_EN_IN;
  assign bus.EXE_MEM_R_EN   = bus.MEM_R_EN_IN;

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
Execute stage of the 5-stage ARM pipeline, directly upstream of the memory stage. It selects forwarded operands, generates the second operand, and runs the ALU. It holds the NZCV status register and computes the branch target. Results are registered into the EXE/MEM pipeline register, which feeds the memory stage's ALUResultIn, storeValue, WBDestIn and enable inputs.

Parameters:
WIDTH, 32, datapath width (fixed at 32; Val2 and branch logic assume it)

Ports:
clk  in  1  clock, rising-edge
rst  in  1  asynchronous, active-low reset
freeze  in  1  stall; holds the EXE/MEM register and SR
EXE_CMD  in  4  ALU opcode
MEM_R_EN_IN, MEM_W_EN_IN, WB_EN_IN, S, B, imm  in  1 each  ID/EXE control bits
PC  in  32  PC+4 of the instruction
Val_Rn, Val_Rm  in  32  register-file operands
shift_operand  in  12  immediate or shift field
signed_imm_24  in  24  branch offset
DestIn  in  4  write-back register
sel_src1, sel_src2  in  2  forwarding selects
MEM_ALUResult, WB_Value  in  32  forwarded values
ALUResult, storeValue  out  32  registered, to the MEM stage
WBDest  out  4  registered
MEM_R_EN, MEM_W_EN, WB_EN  out  1  registered
SR  out  4  status register {N,Z,C,V}, to ID condition check
Branch_taken  out  1  combinational, equals B
Branch_address  out  32  combinational
EXE_WBDest, EXE_WB_EN, EXE_MEM_R_EN  out  4/1/1  combinational pass-through of the inputs, for hazard detection

Behaviour:
- Reset (rst=0, asynchronous): all registered outputs and SR are 0.
- Forwarding, select codes: 00 selects the register value, 01 selects MEM_ALUResult, 10 selects WB_Value, 11 is treated as 00. src1 drives A. The src2 result drives both the Val2 shifter input and storeValue.
- Val2 generation, in priority order:
  - if MEM_R_EN_IN or MEM_W_EN_IN: zero-extended shift_operand.
  - else if imm: {24'b0, shift_operand[7:0]} rotated right by 2*shift_operand[11:8].
  - else: src2 shifted by shift_operand[11:7] using type [6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
  - A shift amount of 0 gives an unshifted value.
- EXE_CMD encoding:
  - 0001 MOV: B.
  - 1001 MVN: ~B.
  - 0010 ADD: A+B.
  - 0011 ADC: A+B+C.
  - 0100 SUB: A-B.
  - 0101 SBC: A-B-!C.
  - 0110 AND, 0111 ORR, 1000 EOR.
  - Any other code gives result 0 and no flag change.
  - LDR/STR use ADD; CMP uses SUB; TST uses AND.
- Flags:
  - N = result[31]; Z = (result==0).
  - Add/sub: C = carry-out of the 33-bit sum; subtraction is computed as A+~B+1, so C=1 means no borrow. V = signed overflow.
  - MOV, MVN and logic ops: C and V keep their current SR value.
- SR update: on a clock edge with S=1 and freeze=0, SR loads the new flags. Otherwise SR holds.
- EXE/MEM register:
  - loads ALUResult, storeValue, WBDest and the three enables on every edge with freeze=0; holds when freeze=1.
  - Latency is 1 cycle from the input to the registered output.
- Branch_address = PC + (sign-extended signed_imm_24 << 2), with 32-bit wrap-around.
- Reset asserted mid-operation clears state immediately, regardless of freeze.

Decomposition:
- Package exe_pkg: EXE_CMD localparams, shift-type codes, forwarding-select codes, and a status_t struct {N,Z,C,V}.
- Sub-module exe_alu, combinational: takes A, Val2, cmd and C in; returns result and next NZCV.
- The Val2 generator, forwarding muxes, SR and EXE/MEM register stay in exe_stage.

Test Plan:
- Reset: hold rst=0 for 2 cycles with nonzero inputs -> all registered outputs and SR read 0. Release reset, then ADD A=5, Val2=3 -> ALUResult=8 one cycle later.
- Flags: SUB with S=1, A=3, Val2=3 -> SR=0110 (Z=1, C=1). Then ADD with S=1, A=0x7FFFFFFF, Val2=1 -> SR=1001 (N=1, V=1). Then MOV with S=0 -> SR unchanged.
- Val2 and forwarding:
  - imm=1, shift_operand=0x4FF -> Val2=0xFF000000.
  - imm=0, ASR #4 of 0x80000000 -> Val2=0xF8000000.
  - STR with sel_src2=01, MEM_ALUResult=0xDEAD -> storeValue=0xDEAD.
- Freeze: freeze=1 for 3 cycles with changing inputs and S=1 -> registered outputs and SR hold. On the first edge after release, the current inputs load.
- ADC/SBC carry chain: set C=1 via SUB 5-3. Then ADC 1+1 -> 3; SBC 5-3 with C=0 -> 1.
- Branch: PC=0x100, signed_imm_24=0xFFFFFE, B=1 -> Branch_address=0xF8 and Branch_taken=1, both in the same cycle.
